body_tracer: RTL



---
 rtl/body_tracer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/body_tracer.sv
// Walks the direction ring once per trace, rebuilding body segments from the head.
// Reports probe occupancy by segments 1..len-1 and the tail segment coordinates.
module body_tracer #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned DEPTH    = 234,
    parameter int unsigned X_BITS   = 5,
    parameter int unsigned Y_BITS   = 5,
    parameter int unsigned GRID_W   = 20,
    parameter int unsigned GRID_H   = 15,
    parameter int unsigned LEN_BITS = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [X_BITS-1:0]   head_x,
    input  logic [Y_BITS-1:0]   head_y,
    input  logic [LEN_BITS-1:0] len,
    input  logic [X_BITS-1:0]   probe_x,
    input  logic [Y_BITS-1:0]   probe_y,
    input  logic [WIDTH-1:0]    dir_in,
    output logic [WIDTH-1:0]    dir_out,
    output logic                shift_en,
    output logic                busy,
    output logic                done,
    output logic                hit,
    output logic [X_BITS-1:0]   tail_x,
    output logic [Y_BITS-1:0]   tail_y
);

    localparam logic [LEN_BITS-1:0] LAST_K  = LEN_BITS'(DEPTH - 1);
    localparam logic [X_BITS-1:0]   X_MAX   = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0]   Y_MAX   = Y_BITS'(GRID_H - 1);

    typedef enum logic {IDLE, TRACE} state_t;

    state_t              state;
    logic [LEN_BITS-1:0] k_q;
    logic [LEN_BITS-1:0] steps_q;
    logic [X_BITS-1:0]   cur_x, probe_xq, tacc_x;
    logic [Y_BITS-1:0]   cur_y, probe_yq, tacc_y;
    logic                hit_acc;

    logic [X_BITS-1:0]   nx, tx_nx;
    logic [Y_BITS-1:0]   ny, ty_nx;
    logic                step, tail_take, hit_nx;
    logic [LEN_BITS-1:0] len_cl;

    // The ring content is preserved by feeding every code straight back.
    assign dir_out = dir_in;

    // Toroidal step of the cursor by the currently sampled code.
    always_comb begin
        nx = cur_x;
        ny = cur_y;
        case (dir_in[1:0])
            2'd0:    nx = (cur_x == X_MAX) ? '0 : cur_x + X_BITS'(1);
            2'd1:    ny = (cur_y == Y_MAX) ? '0 : cur_y + Y_BITS'(1);
            2'd2:    nx = (cur_x == '0) ? X_MAX : cur_x - X_BITS'(1);
            default: ny = (cur_y == '0) ? Y_MAX : cur_y - Y_BITS'(1);
        endcase
    end

    always_comb begin
        step      = (k_q < steps_q);
        tail_take = step && ((k_q + LEN_BITS'(1)) == steps_q);
        hit_nx    = hit_acc | (step && (nx == probe_xq) && (ny == probe_yq));
        tx_nx     = tail_take ? nx : tacc_x;
        ty_nx     = tail_take ? ny : tacc_y;
    end

    always_comb begin
        len_cl = len;
        if (len == '0)
            len_cl = LEN_BITS'(1);
        else if (32'(len) > DEPTH)
            len_cl = LEN_BITS'(DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            k_q      <= '0;
            steps_q  <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            probe_xq <= '0;
            probe_yq <= '0;
            tacc_x   <= '0;
            tacc_y   <= '0;
            hit_acc  <= 1'b0;
            shift_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hit      <= 1'b0;
            tail_x   <= '0;
            tail_y   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= TRACE;
                        busy     <= 1'b1;
                        shift_en <= 1'b1;
                        k_q      <= '0;
                        steps_q  <= len_cl - LEN_BITS'(1);
                        cur_x    <= head_x;
                        cur_y    <= head_y;
                        probe_xq <= probe_x;
                        probe_yq <= probe_y;
                        tacc_x   <= head_x;
                        tacc_y   <= head_y;
                        hit_acc  <= 1'b0;
                    end
                end
                default: begin
                    k_q     <= k_q + LEN_BITS'(1);
                    hit_acc <= hit_nx;
                    tacc_x  <= tx_nx;
                    tacc_y  <= ty_nx;
                    if (step) begin
                        cur_x <= nx;
                        cur_y <= ny;
                    end
                    if (k_q == LAST_K) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        shift_en <= 1'b0;
                        done     <= 1'b1;
                        hit      <= hit_nx;
                        tail_x   <= tx_nx;
                        tail_y   <= ty_nx;
                    end
                end
            endcase
        end
    end

endmodule
